// File: rtl/segre_pkg.sv
// Shared widths, PTE layout and walker state encoding for the segre page-table walker.
// The optional SEGRE_PTW_PERM_CHECK_EN build flag is consumed by segre_ptw.
package segre_pkg;

   localparam int WORD_SIZE          = 32;
   localparam int PHYSICAL_ADDR_SIZE = 20;
   localparam int VIRT_PAGE_BITS     = 20;
   localparam int PHYS_PAGE_BITS     = 8;

   localparam int         PTE_VALID_BIT = 0;
   localparam logic [1:0] PTE_MODE_X    = 2'b11;

   typedef struct packed {
      logic [WORD_SIZE-PHYS_PAGE_BITS-13:0] rsvd;
      logic [PHYS_PAGE_BITS-1:0]            ppage;
      logic [8:0]                           sw;
      logic [1:0]                           mode;
      logic                                 valid;
   } pte_t;

   typedef enum logic [2:0] {
      PTW_IDLE  = 3'd0,
      PTW_REQ   = 3'd1,
      PTW_WAIT  = 3'd2,
      PTW_FILL  = 3'd3,
      PTW_FAULT = 3'd4
   } ptw_state_e;

   // One word-sized PTE per virtual page; the sum wraps within the physical space.
   function automatic logic [PHYSICAL_ADDR_SIZE-1:0] pte_addr(
      input logic [PHYSICAL_ADDR_SIZE-1:0] ptbr,
      input logic [VIRT_PAGE_BITS-1:0]     vpage
   );
      logic [VIRT_PAGE_BITS+1:0] off;
      off = {vpage, 2'b00};
      return ptbr + off[PHYSICAL_ADDR_SIZE-1:0];
   endfunction

endpackage

// File: rtl/segre_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, registered last-served pointer.
// req_i[0] is the I-side, req_i[1] the D-side.
module segre_rr_arb2 (
   input  logic       clk_i,
   input  logic       rsn_i,
   input  logic [1:0] req_i,
   input  logic       update_i,
   input  logic       served_i,
   output logic [1:0] gnt_o
);

   logic last_d_q;

   // Reset as if D was served last so the I-side holds priority first.
   always_ff @(posedge clk_i) begin
      if (!rsn_i)        last_d_q <= 1'b1;
      else if (update_i) last_d_q <= served_i;
   end

   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) gnt_o = last_d_q ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/segre_ptw.sv
// Hardware page-table walker shared by the I- and D-TLBs (single-level table).
// Build flag SEGRE_PTW_PERM_CHECK_EN adds an execute/data permission fault on the PTE mode.
module segre_ptw
   import segre_pkg::*;
(
   input  logic                          clk_i,
   input  logic                          rsn_i,
   input  logic                          itlb_miss_i,
   input  logic [WORD_SIZE-1:0]          itlb_vaddr_i,
   input  logic                          dtlb_miss_i,
   input  logic [WORD_SIZE-1:0]          dtlb_vaddr_i,
   input  logic [PHYSICAL_ADDR_SIZE-1:0] ptbr_i,
   output logic                          mem_req_o,
   output logic [PHYSICAL_ADDR_SIZE-1:0] mem_addr_o,
   input  logic                          mem_gnt_i,
   input  logic                          mem_rvalid_i,
   input  logic [WORD_SIZE-1:0]          mem_rdata_i,
   output logic                          itlb_we_o,
   output logic                          dtlb_we_o,
   output logic [VIRT_PAGE_BITS-1:0]     tlb_vpage_o,
   output logic [PHYS_PAGE_BITS-1:0]     tlb_ppage_o,
   output logic [1:0]                    tlb_mode_o,
   output logic                          fault_o,
   output logic                          fault_is_d_o,
   output logic [WORD_SIZE-1:0]          fault_vaddr_o,
   output logic                          busy_o,
   output ptw_state_e                    dbg_state_o
);

   // Memory handshake: a request is accepted in the cycle where mem_req_o and
   // mem_gnt_i are both 1; the single response is the next mem_rvalid_i pulse.

   ptw_state_e                    state_q, state_d;
   logic [WORD_SIZE-1:0]          vaddr_q;
   logic                          is_d_q;
   logic [PHYSICAL_ADDR_SIZE-1:0] ptbr_q;
   logic [PHYS_PAGE_BITS-1:0]     ppage_q;
   logic [1:0]                    mode_q;
   pte_t                          pte_in;
   logic [1:0]                    arb_gnt;
   logic                          pte_bad;
   logic                          unused_rdata;

   assign pte_in       = pte_t'(mem_rdata_i);
   assign unused_rdata = ^{pte_in.rsvd, pte_in.sw, pte_in.valid};

   segre_rr_arb2 u_arb (
      .clk_i    (clk_i),
      .rsn_i    (rsn_i),
      .req_i    ({dtlb_miss_i, itlb_miss_i}),
      .update_i ((state_q == PTW_FILL) || (state_q == PTW_FAULT)),
      .served_i (is_d_q),
      .gnt_o    (arb_gnt)
   );

   always_comb begin
      pte_bad = !mem_rdata_i[PTE_VALID_BIT];
`ifdef SEGRE_PTW_PERM_CHECK_EN
      // Instruction pages must be executable; data pages must not be.
      if (is_d_q ? (pte_in.mode == PTE_MODE_X) : (pte_in.mode != PTE_MODE_X))
         pte_bad = 1'b1;
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         PTW_IDLE:  if (|arb_gnt) state_d = PTW_REQ;
         PTW_REQ:   if (mem_gnt_i) state_d = PTW_WAIT;
         PTW_WAIT:  if (mem_rvalid_i) state_d = pte_bad ? PTW_FAULT : PTW_FILL;
         PTW_FILL:  state_d = PTW_IDLE;
         PTW_FAULT: state_d = PTW_IDLE;
         default:   state_d = PTW_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         state_q <= PTW_IDLE;
         vaddr_q <= '0;
         is_d_q  <= 1'b0;
         ptbr_q  <= '0;
         ppage_q <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == PTW_IDLE && |arb_gnt) begin
            is_d_q  <= arb_gnt[1];
            vaddr_q <= arb_gnt[1] ? dtlb_vaddr_i : itlb_vaddr_i;
            ptbr_q  <= ptbr_i;
         end
         if (state_q == PTW_WAIT && mem_rvalid_i) begin
            ppage_q <= pte_in.ppage;
            mode_q  <= pte_in.mode;
         end
      end
   end

   // Outputs are forced low while reset is held, even mid-walk.
   always_comb begin
      mem_req_o     = 1'b0;
      mem_addr_o    = '0;
      itlb_we_o     = 1'b0;
      dtlb_we_o     = 1'b0;
      tlb_vpage_o   = '0;
      tlb_ppage_o   = '0;
      tlb_mode_o    = '0;
      fault_o       = 1'b0;
      fault_is_d_o  = 1'b0;
      fault_vaddr_o = '0;
      busy_o        = 1'b0;
      dbg_state_o   = PTW_IDLE;
      if (rsn_i) begin
         busy_o      = (state_q != PTW_IDLE);
         dbg_state_o = state_q;
         case (state_q)
            PTW_REQ: begin
               mem_req_o  = 1'b1;
               mem_addr_o = pte_addr(ptbr_q, vaddr_q[WORD_SIZE-1:12]);
            end
            PTW_FILL: begin
               itlb_we_o   = !is_d_q;
               dtlb_we_o   = is_d_q;
               tlb_vpage_o = vaddr_q[WORD_SIZE-1:12];
               tlb_ppage_o = ppage_q;
               tlb_mode_o  = mode_q;
            end
            PTW_FAULT: begin
               fault_o       = 1'b1;
               fault_is_d_o  = is_d_q;
               fault_vaddr_o = vaddr_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_segre_ptw.sv
// Directed bench for segre_ptw: fills, faults, round-robin order, address wrap,
// grant stall and reset in the middle of a walk.
module tb_segre_ptw;
   import segre_pkg::*;

   logic        clk_i = 1'b0;
   logic        rsn_i;
   logic        itlb_miss_i, dtlb_miss_i;
   logic [31:0] itlb_vaddr_i, dtlb_vaddr_i;
   logic [19:0] ptbr_i;
   logic        mem_req_o, mem_gnt_i, mem_rvalid_i;
   logic [19:0] mem_addr_o;
   logic [31:0] mem_rdata_i;
   logic        itlb_we_o, dtlb_we_o;
   logic [19:0] tlb_vpage_o;
   logic [7:0]  tlb_ppage_o;
   logic [1:0]  tlb_mode_o;
   logic        fault_o, fault_is_d_o, busy_o;
   logic [31:0] fault_vaddr_o;
   ptw_state_e  dbg_state_o;

   segre_ptw dut (
      .clk_i(clk_i), .rsn_i(rsn_i),
      .itlb_miss_i(itlb_miss_i), .itlb_vaddr_i(itlb_vaddr_i),
      .dtlb_miss_i(dtlb_miss_i), .dtlb_vaddr_i(dtlb_vaddr_i),
      .ptbr_i(ptbr_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .itlb_we_o(itlb_we_o), .dtlb_we_o(dtlb_we_o),
      .tlb_vpage_o(tlb_vpage_o), .tlb_ppage_o(tlb_ppage_o), .tlb_mode_o(tlb_mode_o),
      .fault_o(fault_o), .fault_is_d_o(fault_is_d_o), .fault_vaddr_o(fault_vaddr_o),
      .busy_o(busy_o), .dbg_state_o(dbg_state_o)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic        done, is_fault, is_d, addr_stable;
      logic [19:0] addr;
      int          lat, req_cycles;
      logic [19:0] vpage;
      logic [7:0]  ppage;
      logic [1:0]  mode;
      logic [31:0] fvaddr;
   } walk_t;

   int n_checks = 0, n_pass = 0;
   int cnt_we_i = 0, cnt_we_d = 0, cnt_fault = 0, cnt_both = 0;
   int exp_we_i = 0, exp_we_d = 0, exp_fault = 0;

   always @(negedge clk_i) begin
      cnt_we_i  += int'(itlb_we_o);
      cnt_we_d  += int'(dtlb_we_o);
      cnt_fault += int'(fault_o);
      cnt_both  += int'(itlb_we_o & dtlb_we_o);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      else n_pass++;
   endtask

   function automatic logic pte_faults(input logic is_d, input logic [31:0] pte);
      logic bad;
      bad = !pte[0];
`ifdef SEGRE_PTW_PERM_CHECK_EN
      if (is_d ? (pte[2:1] == 2'b11) : (pte[2:1] != 2'b11)) bad = 1'b1;
`endif
      return bad;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk_i);
      rsn_i = 1'b0; itlb_miss_i = 1'b0; dtlb_miss_i = 1'b0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rsn_i = 1'b1;
   endtask

   task automatic start_miss(input logic is_d, input logic [31:0] va, input logic [19:0] ptbr);
      ptbr_i = ptbr;
      if (is_d) begin dtlb_miss_i = 1'b1; dtlb_vaddr_i = va; end
      else      begin itlb_miss_i = 1'b1; itlb_vaddr_i = va; end
   endtask

   // Acts as memory for one walk; latency counts the miss-sampling cycle as cycle 1.
   task automatic serve(input string tag, input logic [31:0] rdata, input int gnt_wait,
                        output walk_t r);
      logic in_wait;
      int   cyc;
      r = '{default: '0};
      r.addr_stable = 1'b1;
      in_wait = 1'b0;
      cyc = 1;
      while (!r.done && cyc < 60) begin
         @(negedge clk_i);
         cyc++;
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
         if (in_wait) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = rdata; in_wait = 1'b0;
         end else if (mem_req_o) begin
            if (r.req_cycles == 0) r.addr = mem_addr_o;
            else if (mem_addr_o !== r.addr) r.addr_stable = 1'b0;
            r.req_cycles++;
            if (r.req_cycles > gnt_wait) begin mem_gnt_i = 1'b1; in_wait = 1'b1; end
         end
         if (itlb_we_o || dtlb_we_o || fault_o) begin
            r.done = 1'b1; r.lat = cyc; r.is_fault = fault_o;
            r.is_d = fault_o ? fault_is_d_o : dtlb_we_o;
            r.vpage = tlb_vpage_o; r.ppage = tlb_ppage_o; r.mode = tlb_mode_o;
            r.fvaddr = fault_vaddr_o;
            if (r.is_d) dtlb_miss_i = 1'b0; else itlb_miss_i = 1'b0;
         end
      end
      check({tag, ".done"}, 32'(r.done), 32'd1);
      @(negedge clk_i);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      check({tag, ".busy_after"}, 32'(busy_o), 32'd0);
   endtask

   task automatic check_walk(input string tag, input walk_t r, input logic is_d,
                             input logic [31:0] va, input logic [31:0] rd,
                             input logic [19:0] exp_addr, input int exp_lat);
      logic f;
      f = pte_faults(is_d, rd);
      check({tag, ".addr"},  32'(r.addr), 32'(exp_addr));
      check({tag, ".lat"},   32'(r.lat), 32'(exp_lat));
      check({tag, ".fault"}, 32'(r.is_fault), 32'(f));
      check({tag, ".side"},  32'(r.is_d), 32'(is_d));
      check({tag, ".vpage"}, 32'(r.vpage), f ? 32'd0 : 32'(va[31:12]));
      check({tag, ".ppage"}, 32'(r.ppage), f ? 32'd0 : 32'(rd[19:12]));
      check({tag, ".mode"},  32'(r.mode), f ? 32'd0 : 32'(rd[2:1]));
      check({tag, ".fvaddr"}, r.fvaddr, f ? va : 32'd0);
      if (f) exp_fault++;
      else if (is_d) exp_we_d++;
      else exp_we_i++;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      walk_t r;
      int    we_before;
      rsn_i = 1'b0; itlb_miss_i = 1'b0; dtlb_miss_i = 1'b0;
      itlb_vaddr_i = '0; dtlb_vaddr_i = '0; ptbr_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

      @(negedge clk_i);
      @(negedge clk_i);
      check("rst.busy", 32'(busy_o), 32'd0);
      check("rst.state", 32'(dbg_state_o), 32'(PTW_IDLE));
      check("rst.req", 32'(mem_req_o), 32'd0);
      do_reset();

      // Basic I-side fill.
      start_miss(1'b0, 32'h0000_3ABC, 20'h10000);
      serve("fill", 32'h0001_2001, 0, r);
      check_walk("fill", r, 1'b0, 32'h0000_3ABC, 32'h0001_2001, 20'h1000C, 4);

      // Invalid PTE -> fault.
      start_miss(1'b0, 32'h0000_3ABC, 20'h10000);
      serve("flt", 32'h0001_2000, 0, r);
      check_walk("flt", r, 1'b0, 32'h0000_3ABC, 32'h0001_2000, 20'h1000C, 4);

      // Round-robin: fresh reset gives the I-side first pick.
      do_reset();
      start_miss(1'b0, 32'h0000_1000, 20'h10000);
      start_miss(1'b1, 32'h0000_8000, 20'h10000);
      serve("rr1", 32'h0005_6001, 0, r);
      check_walk("rr1", r, 1'b0, 32'h0000_1000, 32'h0005_6001, 20'h10004, 4);
      serve("rr2", 32'h0005_6001, 0, r);
      check_walk("rr2", r, 1'b1, 32'h0000_8000, 32'h0005_6001, 20'h10020, 4);
      start_miss(1'b0, 32'h0000_2000, 20'h10000);
      start_miss(1'b1, 32'h0000_9000, 20'h10000);
      serve("rr3", 32'h0003_4007, 0, r);
      check_walk("rr3", r, 1'b0, 32'h0000_2000, 32'h0003_4007, 20'h10008, 4);
      serve("rr4", 32'h0003_4001, 0, r);
      check_walk("rr4", r, 1'b1, 32'h0000_9000, 32'h0003_4001, 20'h10024, 4);

      // Address wrap plus three stalled grant cycles.
      do_reset();
      start_miss(1'b1, 32'h0000_8000, 20'hFFFF0);
      serve("wrap", 32'h0005_6001, 3, r);
      check_walk("wrap", r, 1'b1, 32'h0000_8000, 32'h0005_6001, 20'h00010, 7);
      check("wrap.req_cycles", 32'(r.req_cycles), 32'd4);
      check("wrap.stable", 32'(r.addr_stable), 32'd1);

      // Mode 01 I-side PTE: pass-through, or a fault with permission checks.
      start_miss(1'b0, 32'h0000_3ABC, 20'h10000);
      serve("mode", 32'h0001_2003, 0, r);
      check_walk("mode", r, 1'b0, 32'h0000_3ABC, 32'h0001_2003, 20'h1000C, 4);

      // Reset while waiting for the PTE; the late response must be dropped.
      we_before = cnt_we_i + cnt_we_d + cnt_fault;
      start_miss(1'b0, 32'h0000_3ABC, 20'h10000);
      @(negedge clk_i);
      check("rstw.req", 32'(mem_req_o), 32'd1);
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      check("rstw.wait", 32'(dbg_state_o), 32'(PTW_WAIT));
      rsn_i = 1'b0;
      #1;
      check("rstw.busy_in_rst", 32'(busy_o), 32'd0);
      check("rstw.state_in_rst", 32'(dbg_state_o), 32'(PTW_IDLE));
      itlb_miss_i = 1'b0;
      @(negedge clk_i);
      rsn_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0001_2001; mem_gnt_i = 1'b1;
      @(negedge clk_i);
      mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
      check("rstw.busy", 32'(busy_o), 32'd0);
      repeat (3) @(negedge clk_i);
      check("rstw.busy_late", 32'(busy_o), 32'd0);
      check("rstw.no_pulse", 32'(cnt_we_i + cnt_we_d + cnt_fault), 32'(we_before));

      // Totals across all walks.
      check("tot.we_i", 32'(cnt_we_i), 32'(exp_we_i));
      check("tot.we_d", 32'(cnt_we_d), 32'(exp_we_d));
      check("tot.fault", 32'(cnt_fault), 32'(exp_fault));
      check("tot.both_we", 32'(cnt_both), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/segre_ptw.md
SEGRE_PTW -- requirements
Module: segre_ptw

Interface
REQ-001 The block SHALL expose these ports: clk_i  in  1  single clock; all state changes on rising edge.
REQ-002 rsn_i  in  1  reset, synchronous, active-low.
REQ-003 itlb_miss_i  in  1  / itlb_vaddr_i  in  WORD_SIZE  I-side miss and its faulting virtual address, held by the requester until the fill or fault.
REQ-004 dtlb_miss_i  in  1  / dtlb_vaddr_i  in  WORD_SIZE  D-side miss and its virtual address, same hold rule.
REQ-005 ptbr_i  in  PHYSICAL_ADDR_SIZE  page-table base physical address, word aligned.
REQ-006 mem_req_o  out  1  / mem_addr_o  out  PHYSICAL_ADDR_SIZE  / mem_gnt_i  in  1  PTE read request, address and grant.
REQ-007 mem_rvalid_i  in  1  / mem_rdata_i  in  WORD_SIZE  PTE read response.
REQ-008 itlb_we_o  out  1  / dtlb_we_o  out  1  / tlb_vpage_o  out  VIRT_PAGE_BITS  / tlb_ppage_o  out  PHYS_PAGE_BITS  / tlb_mode_o  out  2  TLB refill write port.
REQ-009 fault_o  out  1  / fault_is_d_o  out  1  / fault_vaddr_o  out  WORD_SIZE  page-fault report; busy_o  out  1  walk in progress.

Function
REQ-010 The FSM SHALL have states IDLE, REQ, WAIT, FILL and FAULT.
REQ-011 In IDLE with any miss asserted, the block SHALL capture the winner's vaddr, its side and ptbr_i, then enter REQ on the next edge.
REQ-012 Arbitration SHALL be two-way round-robin: when both sides miss, the side not served last wins; a lone requester always wins.
REQ-013 The priority pointer SHALL update only on leaving FILL or FAULT.
REQ-014 In REQ, mem_req_o SHALL be 1 with mem_addr_o = captured ptbr + (vaddr[31:12] << 2), truncated modulo 2^PHYSICAL_ADDR_SIZE; the state SHALL be held until mem_gnt_i, then move to WAIT.
REQ-015 In WAIT, the block SHALL capture mem_rdata_i on mem_rvalid_i: PTE bit0 = valid, bits[2:1] = mode, bits[PHYS_PAGE_BITS+11:12] = ppage.
REQ-016 A valid PTE SHALL lead to FILL; an invalid one SHALL lead to FAULT.
REQ-017 FILL SHALL last exactly one cycle: the winner's we output is 1, tlb_vpage_o = vaddr[31:12], tlb_ppage_o and tlb_mode_o come from the PTE; then IDLE.
REQ-018 FAULT SHALL last exactly one cycle: fault_o=1, fault_is_d_o = side, fault_vaddr_o = captured vaddr; then IDLE.
REQ-019 busy_o SHALL be 1 in every state except IDLE.
REQ-020 Miss inputs deasserting mid-walk SHALL NOT abort the walk; the fill still occurs.
REQ-021 mem_rvalid_i outside WAIT, and mem_gnt_i outside REQ, SHALL be ignored.
REQ-022 Both we outputs SHALL never be 1 in the same cycle; a miss arriving during a walk SHALL wait for IDLE.
REQ-023 Minimum latency from miss sampled in IDLE to we pulse SHALL be 4 cycles, given a grant in the first REQ cycle and rvalid on the first WAIT cycle.

Reset
REQ-024 With rsn_i=0 at a clock edge, the block SHALL enter IDLE and point priority to the I-side.
REQ-025 During reset, all outputs SHALL be 0, including while a walk is in progress; any later response for the aborted walk SHALL be ignored per REQ-021.

Configuration
REQ-026 SEGRE_PTW_PERM_CHECK_EN defined: an I-side PTE with mode != 2'b11 (X), or a D-side PTE with mode == 2'b11, SHALL take FAULT even when valid.
REQ-027 SEGRE_PTW_PERM_CHECK_EN undefined: mode SHALL be passed through and never cause a fault.

Structure
REQ-028 segre_pkg SHALL hold the pte_t packed typedef, the ptw_state_e enum, and the PTE_VALID_BIT and PTE_MODE_X constants; widths SHALL reuse the existing WORD_SIZE, PHYSICAL_ADDR_SIZE, VIRT_PAGE_BITS and PHYS_PAGE_BITS.
REQ-029 The round-robin pick SHALL be the sub-module segre_rr_arb2 (two requests, registered last-served pointer, one-hot grant).

Verification
REQ-030 The bench SHALL cover: ptbr=0x10000, itlb miss vaddr=0x00003ABC, gnt and rvalid immediate, rdata=0x00012001 -> mem_addr_o=0x1000C; itlb_we_o pulses once at cycle 4 with vpage=0x00003 and ppage=0x12.
REQ-031 Same stimulus with rdata=0x00012000 -> fault_o pulses once, fault_vaddr_o=0x00003ABC, fault_is_d_o=0, no we pulse.
REQ-032 Both misses asserted together after reset -> I-side walked first, then D-side; a subsequent simultaneous pair -> I-side first again, since D was served last.
REQ-033 ptbr=0xFFFF0, dtlb vaddr=0x00008000 -> mem_addr_o=0x00010 (wrap); gnt held low 3 cycles -> mem_req_o stays 1 with a stable address.
REQ-034 rsn_i=0 for one cycle in WAIT, then rvalid with a valid PTE -> no we pulse and busy_o=0.
REQ-035 With SEGRE_PTW_PERM_CHECK_EN: I-side PTE=0x00012003 (mode 01) -> fault_o; without the macro -> itlb_we_o with tlb_mode_o=01.
